// File: rtl/rdma_rc_pkg.sv
// rtl/rdma_rc_pkg.sv - shared constants and types for the RC receive PSN checker
//
// Purpose: QP state encodings, checker FSM states, default PSN width and the
//          opcode bit that carries the ack-request / last-packet indication.
// Ports:   none (package).
package rdma_rc_pkg;

   localparam int PSN_WIDTH_DEF  = 24;
   localparam int OPC_ACKREQ_BIT = 0;

   localparam logic [2:0] QP_RESET = 3'b000;
   localparam logic [2:0] QP_INIT  = 3'b001;
   localparam logic [2:0] QP_RTR   = 3'b010;
   localparam logic [2:0] QP_RTS   = 3'b011;
   localparam logic [2:0] QP_ERROR = 3'b111;

   typedef enum logic [0:0] {
      FSM_NORMAL   = 1'b0,
      FSM_NAK_SENT = 1'b1
   } fsm_state_e;

   // Register-level encodings kept as plain constants for legacy tooling.
   localparam logic [0:0] ST_NORMAL   = FSM_NORMAL;
   localparam logic [0:0] ST_NAK_SENT = FSM_NAK_SENT;

   // Receive-side processing is only legal once the QP reached RTR.
   function automatic logic qp_rx_active(input logic [2:0] state);
      case (state)
         QP_RTR, QP_RTS:            return 1'b1;
         QP_RESET, QP_INIT, QP_ERROR: return 1'b0;
         default:                   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rdma_rc_psn_checker_if.sv
// rtl/rdma_rc_psn_checker_if.sv - ACK/NAK response handshake bundle
//
// Purpose: carries one ACK/NAK response from the checker to the responder.
// Signals: ack_valid  - response present
//          ack_ready  - consumer accepts response
//          ack_is_nak - 1 = NAK (sequence error), 0 = ACK
//          ack_psn    - ACK: last in-order PSN, NAK: expected PSN
// Modports: master = checker side, slave = consumer side.
interface rdma_rc_psn_checker_if #(
   parameter int PSN_WIDTH = 24
);
   logic                 ack_valid;
   logic                 ack_ready;
   logic                 ack_is_nak;
   logic [PSN_WIDTH-1:0] ack_psn;

   modport master (output ack_valid, output ack_is_nak, output ack_psn, input ack_ready);
   modport slave  (input ack_valid, input ack_is_nak, input ack_psn, output ack_ready);
endinterface

// File: rtl/rdma_rc_ack_slot.sv
// rtl/rdma_rc_ack_slot.sv - one-entry ACK/NAK response buffer
//
// Purpose: holds a single pending response; a newer candidate replaces a
//          queued ACK, a NAK replaces a queued ACK, an ACK never replaces a
//          queued NAK.
// Ports:   clk, rst_n           - clock, async active-low reset
//          i_clear              - drop any pending response
//          i_cand_valid/nak/psn - new response candidate
//          i_ready              - consumer accepts current response
//          o_valid/o_is_nak/o_psn - pending response
module rdma_rc_ack_slot #(
   parameter int PSN_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_clear,
   input  logic                 i_cand_valid,
   input  logic                 i_cand_nak,
   input  logic [PSN_WIDTH-1:0] i_cand_psn,
   input  logic                 i_ready,
   output logic                 o_valid,
   output logic                 o_is_nak,
   output logic [PSN_WIDTH-1:0] o_psn
);
   logic                 r_valid;
   logic                 r_is_nak;
   logic [PSN_WIDTH-1:0] r_psn;
   logic                 w_load;

   // Load when empty, when the current entry leaves this cycle, or when the
   // candidate is allowed to overwrite (only an ACK over a NAK is refused).
   assign w_load = i_cand_valid & (~r_valid | i_ready | i_cand_nak | ~r_is_nak);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid  <= 1'b0;
         r_is_nak <= 1'b0;
         r_psn    <= '0;
      end else if (i_clear) begin
         r_valid  <= 1'b0;
         r_is_nak <= 1'b0;
         r_psn    <= '0;
      end else if (w_load) begin
         r_valid  <= 1'b1;
         r_is_nak <= i_cand_nak;
         r_psn    <= i_cand_psn;
      end else if (r_valid && i_ready) begin
         r_valid  <= 1'b0;
      end
   end

   assign o_valid  = r_valid;
   assign o_is_nak = r_is_nak;
   assign o_psn    = r_psn;
endmodule

// File: rtl/rdma_rc_psn_checker.sv
// rtl/rdma_rc_psn_checker.sv - RC receive-side PSN sequence checker
//
// Purpose: classifies parsed data frames as in-order / ahead / duplicate
//          against the expected PSN, advances the expected PSN, produces
//          ACK/NAK responses through a one-entry slot and keeps saturating
//          statistics.
// Optional: RDMA_RC_ACK_COALESCE_EN - coalesce in-order ACKs, one per
//          ACK_COALESCE_N frames or on an ack-request opcode.
// Ports:   clk, rst_n              - clock, async active-low reset
//          i_parse_done ... i_qpn_mismatch_err - parser result, qualified by i_parse_done
//          i_qp_state              - QP state
//          i_epsn_load/i_init_epsn - expected PSN initialisation
//          ack_if (master)         - ACK/NAK response handshake
//          o_data_accept           - in-order data frame accepted strobe
//          o_epsn                  - current expected PSN
//          o_dup_cnt/o_seq_err_cnt/o_drop_cnt - saturating counters
module rdma_rc_psn_checker
   import rdma_rc_pkg::*;
#(
   parameter int PSN_WIDTH      = PSN_WIDTH_DEF,
   parameter int OPCODE_WIDTH   = 8,
   parameter int CNT_WIDTH      = 16,
   parameter int ACK_COALESCE_N = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_parse_done,
   input  logic [OPCODE_WIDTH-1:0] i_pdu_opcode,
   input  logic [PSN_WIDTH-1:0]    i_pdu_psn,
   input  logic                    i_is_data_frame,
   input  logic                    i_opcode_err,
   input  logic                    i_qpn_mismatch_err,
   input  logic [2:0]              i_qp_state,
   input  logic                    i_epsn_load,
   input  logic [PSN_WIDTH-1:0]    i_init_epsn,
   rdma_rc_psn_checker_if.master   ack_if,
   output logic                    o_data_accept,
   output logic [PSN_WIDTH-1:0]    o_epsn,
   output logic [CNT_WIDTH-1:0]    o_dup_cnt,
   output logic [CNT_WIDTH-1:0]    o_seq_err_cnt,
   output logic [CNT_WIDTH-1:0]    o_drop_cnt
);
   logic [0:0]           r_state;
   logic [PSN_WIDTH-1:0] r_epsn;
   logic                 r_data_accept;
   logic [CNT_WIDTH-1:0] r_dup_cnt;
   logic [CNT_WIDTH-1:0] r_seq_err_cnt;
   logic [CNT_WIDTH-1:0] r_drop_cnt;

   logic                 w_qp_active;
   logic                 w_err;
   logic                 w_frame;
   logic                 w_drop;
   logic [PSN_WIDTH-1:0] w_diff;
   logic                 w_in_order;
   logic                 w_ahead;
   logic                 w_dup;
   logic                 w_ack_gen;
   logic                 w_cand_valid;
   logic                 w_cand_nak;
   logic [PSN_WIDTH-1:0] w_cand_psn;
   logic                 w_unused_opc;
   logic                 w_unused_cfg;

   assign w_qp_active = qp_rx_active(i_qp_state);
   assign w_err       = i_opcode_err | i_qpn_mismatch_err;
   // A same-cycle epsn load wins: the parser result is ignored entirely.
   assign w_frame     = i_parse_done & i_is_data_frame & ~w_err & w_qp_active & ~i_epsn_load;
   assign w_drop      = i_parse_done & w_err & ~i_epsn_load;

   // Modular distance: upper half of the PSN space counts as "behind".
   assign w_diff      = i_pdu_psn - r_epsn;
   assign w_in_order  = w_frame & (w_diff == '0);
   assign w_ahead     = w_frame & (w_diff != '0) & ~w_diff[PSN_WIDTH-1];
   assign w_dup       = w_frame & w_diff[PSN_WIDTH-1];

   assign w_unused_opc = ^i_pdu_opcode;
   assign w_unused_cfg = (ACK_COALESCE_N > 0);

`ifdef RDMA_RC_ACK_COALESCE_EN
   localparam int COAL_W = $clog2(ACK_COALESCE_N + 1);
   logic [COAL_W-1:0] r_coal_cnt;
   logic [COAL_W-1:0] w_coal_next;

   assign w_coal_next = r_coal_cnt + 1'b1;
   assign w_ack_gen   = w_in_order &
                        ((int'(w_coal_next) >= ACK_COALESCE_N) | i_pdu_opcode[OPC_ACKREQ_BIT]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_coal_cnt <= '0;
      end else if (i_epsn_load) begin
         r_coal_cnt <= '0;
      end else if (w_in_order) begin
         r_coal_cnt <= w_ack_gen ? '0 : w_coal_next;
      end
   end
`else
   assign w_ack_gen = w_in_order;
`endif

   // Only the first out-of-order frame after an in-order run earns a NAK.
   always_comb begin
      w_cand_valid = 1'b0;
      w_cand_nak   = 1'b0;
      w_cand_psn   = i_pdu_psn;
      if (w_ahead && r_state == ST_NORMAL) begin
         w_cand_valid = 1'b1;
         w_cand_nak   = 1'b1;
         w_cand_psn   = r_epsn;
      end else if (w_dup) begin
         w_cand_valid = 1'b1;
         w_cand_psn   = r_epsn - 1'b1;
      end else if (w_ack_gen) begin
         w_cand_valid = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_NORMAL;
         r_epsn        <= '0;
         r_data_accept <= 1'b0;
         r_dup_cnt     <= '0;
         r_seq_err_cnt <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_data_accept <= w_in_order;
         if (i_epsn_load) begin
            r_epsn  <= i_init_epsn;
            r_state <= ST_NORMAL;
         end else if (!w_qp_active) begin
            r_state <= ST_NORMAL;
         end else if (w_in_order) begin
            r_epsn  <= r_epsn + 1'b1;
            r_state <= ST_NORMAL;
         end else if (w_ahead) begin
            r_state <= ST_NAK_SENT;
         end
         if (w_ahead && r_seq_err_cnt != '1) r_seq_err_cnt <= r_seq_err_cnt + 1'b1;
         if (w_dup   && r_dup_cnt     != '1) r_dup_cnt     <= r_dup_cnt + 1'b1;
         if (w_drop  && r_drop_cnt    != '1) r_drop_cnt    <= r_drop_cnt + 1'b1;
      end
   end

   logic                 w_slot_valid;
   logic                 w_slot_nak;
   logic [PSN_WIDTH-1:0] w_slot_psn;

   rdma_rc_ack_slot #(.PSN_WIDTH(PSN_WIDTH)) u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clear      (~w_qp_active),
      .i_cand_valid (w_cand_valid),
      .i_cand_nak   (w_cand_nak),
      .i_cand_psn   (w_cand_psn),
      .i_ready      (ack_if.ack_ready),
      .o_valid      (w_slot_valid),
      .o_is_nak     (w_slot_nak),
      .o_psn        (w_slot_psn)
   );

   assign ack_if.ack_valid  = w_slot_valid;
   assign ack_if.ack_is_nak = w_slot_nak;
   assign ack_if.ack_psn    = w_slot_psn;

   assign o_data_accept = r_data_accept;
   assign o_epsn        = r_epsn;
   assign o_dup_cnt     = r_dup_cnt;
   assign o_seq_err_cnt = r_seq_err_cnt;
   assign o_drop_cnt    = r_drop_cnt;
endmodule

// File: tb/tb_rdma_rc_psn_checker.sv
// tb/tb_rdma_rc_psn_checker.sv - scoreboard bench for the RC PSN checker
module tb_rdma_rc_psn_checker;
   localparam longint MOD = 64'd1 << 24;
   localparam int CMAX = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_parse_done;
   logic [7:0]  i_pdu_opcode;
   logic [23:0] i_pdu_psn;
   logic        i_is_data_frame;
   logic        i_opcode_err;
   logic        i_qpn_mismatch_err;
   logic [2:0]  i_qp_state;
   logic        i_epsn_load;
   logic [23:0] i_init_epsn;
   logic        o_data_accept;
   logic [23:0] o_epsn;
   logic [3:0]  o_dup_cnt;
   logic [3:0]  o_seq_err_cnt;
   logic [3:0]  o_drop_cnt;

   rdma_rc_psn_checker_if #(.PSN_WIDTH(24)) ack_if ();

   rdma_rc_psn_checker #(
      .PSN_WIDTH(24), .OPCODE_WIDTH(8), .CNT_WIDTH(4), .ACK_COALESCE_N(4)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .i_parse_done       (i_parse_done),
      .i_pdu_opcode       (i_pdu_opcode),
      .i_pdu_psn          (i_pdu_psn),
      .i_is_data_frame    (i_is_data_frame),
      .i_opcode_err       (i_opcode_err),
      .i_qpn_mismatch_err (i_qpn_mismatch_err),
      .i_qp_state         (i_qp_state),
      .i_epsn_load        (i_epsn_load),
      .i_init_epsn        (i_init_epsn),
      .ack_if             (ack_if),
      .o_data_accept      (o_data_accept),
      .o_epsn             (o_epsn),
      .o_dup_cnt          (o_dup_cnt),
      .o_seq_err_cnt      (o_seq_err_cnt),
      .o_drop_cnt         (o_drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {bit nak; longint psn;} resp_t;
   resp_t  exp_q[$];
   int     n_tests = 0;
   int     n_fail  = 0;
   int     n_pop   = 0;

   // Reference model state
   longint m_epsn;
   bit     m_nak_sent;
   int     m_dup, m_seq, m_drop;
   bit     m_accept;
   bit     m_sv, m_snak;
   longint m_spsn;

   function automatic int sat(input int v);
      return (v < CMAX) ? v + 1 : CMAX;
   endfunction

   task automatic chk(input string nm, input longint act, input longint expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
      end
   endtask

   // Monitor: every accepted response must match the oldest predicted one.
   always @(negedge clk) begin
      if (rst_n && ack_if.ack_valid && ack_if.ack_ready) begin
         n_pop++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ack: got nak=%0d psn=0x%0h expected none", ack_if.ack_is_nak, ack_if.ack_psn);
         end else begin
            resp_t r;
            r = exp_q.pop_front();
            chk("ack_is_nak", longint'(ack_if.ack_is_nak), longint'(r.nak));
            chk("ack_psn", longint'(ack_if.ack_psn), r.psn);
         end
      end
   end

   task automatic model_reset();
      m_epsn = 0; m_nak_sent = 0; m_dup = 0; m_seq = 0; m_drop = 0;
      m_accept = 0; m_sv = 0; m_snak = 0; m_spsn = 0;
   endtask

   task automatic drive_idle();
      i_parse_done = 0; i_pdu_opcode = 0; i_pdu_psn = 0; i_is_data_frame = 0;
      i_opcode_err = 0; i_qpn_mismatch_err = 0; i_qp_state = 3'b011;
      i_epsn_load = 0; i_init_epsn = 0; ack_if.ack_ready = 0;
   endtask

   task automatic check_state();
      chk("epsn", longint'(o_epsn), m_epsn);
      chk("data_accept", longint'(o_data_accept), longint'(m_accept));
      chk("dup_cnt", longint'(o_dup_cnt), longint'(m_dup));
      chk("seq_err_cnt", longint'(o_seq_err_cnt), longint'(m_seq));
      chk("drop_cnt", longint'(o_drop_cnt), longint'(m_drop));
      chk("ack_valid", longint'(ack_if.ack_valid), longint'(m_sv));
      if (m_sv) begin
         chk("slot_is_nak", longint'(ack_if.ack_is_nak), longint'(m_snak));
         chk("slot_psn", longint'(ack_if.ack_psn), m_spsn);
      end
   endtask

   // One clock of stimulus; the model predicts the effect of the next edge.
   task automatic step(input bit pd, input longint psn, input bit [7:0] opc, input bit isd,
                       input bit oe, input bit qe, input bit [2:0] qps, input bit ld,
                       input longint ip, input bit rdy);
      bit     active, cand, cnak;
      longint cpsn, d;
      @(posedge clk);
      #1;
      check_state();
      i_parse_done = pd; i_pdu_psn = psn[23:0]; i_pdu_opcode = opc; i_is_data_frame = isd;
      i_opcode_err = oe; i_qpn_mismatch_err = qe; i_qp_state = qps;
      i_epsn_load = ld; i_init_epsn = ip[23:0]; ack_if.ack_ready = rdy;

      active = (qps == 3'b010) || (qps == 3'b011);
      if (m_sv && rdy) begin
         exp_q.push_back('{nak: m_snak, psn: m_spsn});
         m_sv = 0;
      end
      cand = 0; cnak = 0; cpsn = 0; m_accept = 0;
      if (ld) begin
         m_epsn = ip; m_nak_sent = 0;
      end else begin
         if (pd && (oe || qe)) m_drop = sat(m_drop);
         if (!active) m_nak_sent = 0;
         else if (pd && isd && !oe && !qe) begin
            d = (psn - m_epsn + MOD) % MOD;
            if (d == 0) begin
               m_accept = 1; cand = 1; cpsn = psn;
               m_epsn = (m_epsn + 1) % MOD; m_nak_sent = 0;
            end else if (d < MOD / 2) begin
               m_seq = sat(m_seq);
               if (!m_nak_sent) begin cand = 1; cnak = 1; cpsn = m_epsn; m_nak_sent = 1; end
            end else begin
               m_dup = sat(m_dup); cand = 1; cpsn = (m_epsn + MOD - 1) % MOD;
            end
         end
      end
      if (!active) m_sv = 0;
      else if (cand && !(m_sv && m_snak && !cnak)) begin
         m_sv = 1; m_snak = cnak; m_spsn = cpsn;
      end
   endtask

   task automatic frame(input longint psn, input bit rdy = 1);
      step(1, psn, 8'h00, 1, 0, 0, 3'b011, 0, 0, rdy);
   endtask
   task automatic idle(input bit rdy = 1);
      step(0, 0, 8'h00, 0, 0, 0, 3'b011, 0, 0, rdy);
   endtask
   task automatic load(input longint p);
      step(0, 0, 8'h00, 0, 0, 0, 3'b011, 1, p, 1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      drive_idle();
      rst_n = 0;
      #2;
      chk("rst_ack_valid", longint'(ack_if.ack_valid), 0);
      chk("rst_ack_is_nak", longint'(ack_if.ack_is_nak), 0);
      chk("rst_ack_psn", longint'(ack_if.ack_psn), 0);
      chk("rst_data_accept", longint'(o_data_accept), 0);
      chk("rst_epsn", longint'(o_epsn), 0);
      chk("rst_counters", longint'({o_dup_cnt, o_seq_err_cnt, o_drop_cnt}), 0);
      chk("rst_queue_empty", longint'(exp_q.size()), 0);
      @(negedge clk);
      rst_n = 1;
      model_reset();
   endtask

   initial begin
      int pops0;
      drive_idle();
      model_reset();
      rst_n = 0;
      #12;
      rst_n = 1;

      // In-order stream with immediate ready
      load(24'h000010);
      frame(24'h10); frame(24'h11); idle(); idle();
      chk("epsn_inorder", longint'(o_epsn), 24'h000012);

      // Wrap of the expected PSN
      load(24'hFFFFFF);
      frame(24'hFFFFFF); idle(); idle();
      chk("epsn_wrap", longint'(o_epsn), 24'h000000);

      // Gap: a single NAK, then recovery
      load(24'h20);
      frame(24'h22); frame(24'h23); frame(24'h20); idle(); idle();
      chk("seq_err_gap", longint'(o_seq_err_cnt), 2);
      chk("epsn_after_gap", longint'(o_epsn), 24'h21);

      // Duplicate
      load(24'h30);
      frame(24'h2E); idle(); idle();
      chk("dup_cnt_dup", longint'(o_dup_cnt), 1);
      chk("epsn_dup", longint'(o_epsn), 24'h30);

      // Back-pressure: ACKs overwritten, NAK wins the slot
      load(24'h40);
      frame(24'h40, 0); frame(24'h41, 0); frame(24'h42, 0); frame(24'h45, 0); idle(0);
      chk("held_valid", longint'(ack_if.ack_valid), 1);
      chk("held_is_nak", longint'(ack_if.ack_is_nak), 1);
      chk("held_psn", longint'(ack_if.ack_psn), 24'h43);
      pops0 = n_pop;
      idle(1); idle(1);
      chk("single_handshake", longint'(n_pop - pops0), 1);

      // Parser error drops the frame
      load(24'h50);
      step(1, 24'h50, 8'h00, 1, 1, 0, 3'b011, 0, 0, 1); idle();
      chk("drop_cnt_err", longint'(o_drop_cnt), 1);
      chk("epsn_err", longint'(o_epsn), 24'h50);
      chk("no_resp_err", longint'(ack_if.ack_valid), 0);

      // Reset with a response pending
      frame(24'h50, 0); idle(0);
      do_reset();

      // QP leaves RTS: slot cleared, frames ignored
      frame(24'h0, 0);
      step(0, 0, 8'h00, 0, 0, 0, 3'b001, 0, 0, 0);
      step(1, 24'h1, 8'h00, 1, 0, 0, 3'b111, 0, 0, 0);
      idle(1); idle(1);

      // Randomised traffic around the expected PSN, including wrap
      load(24'hFFFFFA);
      for (int i = 0; i < 600; i++) begin
         bit          pd, isd, oe, qe, ld, rdy;
         bit [2:0]    qps;
         longint      psn, ip;
         int          sel;
         pd  = ($urandom_range(0, 3) != 0);
         isd = ($urandom_range(0, 9) != 0);
         oe  = ($urandom_range(0, 19) == 0);
         qe  = ($urandom_range(0, 19) == 0);
         ld  = ($urandom_range(0, 49) == 0);
         ip  = ($urandom_range(0, 1) != 0) ? longint'($urandom_range(0, 'hFFFFFF))
                                            : longint'(24'hFFFFF8 + $urandom_range(0, 15)) % MOD;
         rdy = ($urandom_range(0, 3) != 0);
         sel = $urandom_range(0, 19);
         qps = (sel == 0) ? 3'b001 : (sel == 1) ? 3'b111 : (sel == 2) ? 3'b000 :
               (sel < 8) ? 3'b010 : 3'b011;
         if ($urandom_range(0, 9) == 0) psn = longint'($urandom_range(0, 'hFFFFFF));
         else psn = (m_epsn + longint'($urandom_range(0, 8)) - 4 + MOD) % MOD;
         step(pd, psn, 8'($urandom_range(0, 255)), isd, oe, qe, qps, ld, ip, rdy);
      end
      idle(1); idle(1); idle(1);
      chk("final_queue_empty", longint'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
